// File: rtl/rvx_board_pkg.sv
// Shared constants for rvx board tops: run-controller state encoding and button timing defaults.
package rvx_board_pkg;

  localparam logic [1:0] STATE_HOLD         = 2'd0;
  localparam logic [1:0] STATE_WAIT_RELEASE = 2'd1;
  localparam logic [1:0] STATE_RUN          = 2'd2;
  localparam logic [1:0] STATE_HALTED       = 2'd3;

  typedef enum logic [1:0] {
    StHold        = STATE_HOLD,
    StWaitRelease = STATE_WAIT_RELEASE,
    StRun         = STATE_RUN,
    StHalted      = STATE_HALTED
  } run_state_e;

  // 10 ms at 12 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 120000;
  localparam int unsigned DEFAULT_SYNC_STAGES       = 2;
  localparam int unsigned DEFAULT_RESET_HOLD_CYCLES = 16;

endpackage

// File: rtl/rvx_button_debouncer.sv
// Synchronizes one asynchronous pushbutton and accepts a level change only after it has been
// stable for DEBOUNCE_CYCLES consecutive cycles.
module rvx_button_debouncer import rvx_board_pkg::*; #(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic level_out
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [CntW-1:0]        r_count;

  logic w_synced;
  logic w_differ;
  logic w_expire;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_synced != r_level);
  assign w_expire = (r_count == CntW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], button_in};
      // Any return to the accepted level restarts the stability window.
      if (!w_differ) begin
        r_count <= '0;
      end else if (w_expire) begin
        r_level <= w_synced;
        r_count <= '0;
      end else begin
        r_count <= r_count + CntW'(1);
      end
    end
  end

  assign level_out = r_level;

endmodule

// File: rtl/rvx_run_controller.sv
// Board-level reset/halt sequencer for the rvx core: debounced buttons, stretched core reset and
// a halt toggle, with all outputs registered.
module rvx_run_controller import rvx_board_pkg::*; #(
  parameter int unsigned SYNC_STAGES       = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic reset_button,
  input  logic halt_button,
  output logic core_reset,
  output logic core_halt,
  output logic running
);

  localparam int unsigned HoldW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

  logic w_rst_level;
  logic w_halt_level;
  logic w_halt_press;
  logic w_hold_done;

  logic             r_halt_prev;
  logic [HoldW-1:0] r_hold_cnt;
  run_state_e       r_state;
  logic             r_core_reset;
  logic             r_core_halt;
  logic             r_running;

  rvx_button_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_reset_debouncer (
    .clock     (clock),
    .reset     (reset),
    .button_in (reset_button),
    .level_out (w_rst_level)
  );

  rvx_button_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_halt_debouncer (
    .clock     (clock),
    .reset     (reset),
    .button_in (halt_button),
    .level_out (w_halt_level)
  );

  assign w_halt_press = w_halt_level & ~r_halt_prev;
  assign w_hold_done  = (r_hold_cnt == HoldW'(RESET_HOLD_CYCLES - 1));

  // Outputs are assigned alongside each state transition so they always match the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StHold;
      r_hold_cnt   <= '0;
      r_halt_prev  <= 1'b0;
      r_core_reset <= 1'b1;
      r_core_halt  <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      // Edge register follows the level in every state, so presses in HOLD are dropped.
      r_halt_prev  <= w_halt_level;
      r_hold_cnt   <= '0;
      r_core_reset <= 1'b1;
      r_core_halt  <= 1'b0;
      r_running    <= 1'b0;
      unique case (r_state)
        StHold: begin
          if (w_hold_done) begin
            if (w_rst_level) begin
              r_state <= StWaitRelease;
            end else begin
              r_state      <= StRun;
              r_core_reset <= 1'b0;
              r_running    <= 1'b1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HoldW'(1);
          end
        end
        StWaitRelease: begin
          if (!w_rst_level) begin
            r_state <= StHold;
          end
        end
        StRun: begin
          if (w_rst_level) begin
            r_state <= StWaitRelease;
          end else if (w_halt_press) begin
            r_state      <= StHalted;
            r_core_reset <= 1'b0;
            r_core_halt  <= 1'b1;
          end else begin
            r_core_reset <= 1'b0;
            r_running    <= 1'b1;
          end
        end
        StHalted: begin
          if (w_rst_level) begin
            r_state <= StWaitRelease;
          end else if (w_halt_press) begin
            r_state      <= StRun;
            r_core_reset <= 1'b0;
            r_running    <= 1'b1;
          end else begin
            r_core_reset <= 1'b0;
            r_core_halt  <= 1'b1;
          end
        end
        default: begin
          r_state <= StHold;
        end
      endcase
    end
  end

  assign core_reset = r_core_reset;
  assign core_halt  = r_core_halt;
  assign running    = r_running;

endmodule

// File: tb/tb_rvx_run_controller.sv
// Directed bench for rvx_run_controller with short debounce/hold settings.
module tb_rvx_run_controller;

  logic clock;
  logic reset;
  logic reset_button;
  logic halt_button;
  logic core_reset;
  logic core_halt;
  logic running;

  int n_checks;
  int n_errors;

  localparam logic [2:0] OutHold = 3'b100;
  localparam logic [2:0] OutRun  = 3'b001;
  localparam logic [2:0] OutHalt = 3'b010;

  rvx_run_controller #(
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (4),
    .RESET_HOLD_CYCLES (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .reset_button (reset_button),
    .halt_button  (halt_button),
    .core_reset   (core_reset),
    .core_halt    (core_halt),
    .running      (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {reset,halt,run}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_expect(input string tag, input int n, input logic [2:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, {core_reset, core_halt, running}, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    reset_button = 1'b0;
    halt_button  = 1'b0;

    // 1. Power-on: 3 reset cycles, then 8 cycles of core_reset before RUN.
    run_expect("por_reset", 3, OutHold);
    reset = 1'b0;
    run_expect("por_hold", 7, OutHold);
    run_expect("por_run", 1, OutRun);

    // 2. Glitch rejection, then a valid halt press.
    halt_button = 1'b1;
    run_expect("glitch_hi", 3, OutRun);
    halt_button = 1'b0;
    run_expect("glitch_lo", 10, OutRun);
    halt_button = 1'b1;
    run_expect("halt_latency", 6, OutRun);
    run_expect("halt_on", 1, OutHalt);
    run_expect("halt_held", 3, OutHalt);
    halt_button = 1'b0;
    run_expect("halt_release", 10, OutHalt);

    // 3. Second press resumes.
    halt_button = 1'b1;
    run_expect("resume_latency", 6, OutHalt);
    run_expect("resume_on", 1, OutRun);
    run_expect("resume_held", 3, OutRun);
    halt_button = 1'b0;
    run_expect("resume_release", 10, OutRun);

    // 4. Button reset held 20 cycles.
    reset_button = 1'b1;
    run_expect("btnrst_latency", 6, OutRun);
    run_expect("btnrst_on", 1, OutHold);
    run_expect("btnrst_held", 13, OutHold);
    reset_button = 1'b0;
    run_expect("btnrst_release", 14, OutHold);
    run_expect("btnrst_run", 1, OutRun);

    // 5. Both buttons together: reset wins and the halt press is discarded.
    reset_button = 1'b1;
    halt_button  = 1'b1;
    run_expect("both_latency", 6, OutRun);
    run_expect("both_on", 1, OutHold);
    run_expect("both_held", 3, OutHold);
    reset_button = 1'b0;
    halt_button  = 1'b0;
    run_expect("both_release", 14, OutHold);
    run_expect("both_run", 11, OutRun);

    // 6. Block reset pulse while halted.
    halt_button = 1'b1;
    run_expect("pre_halt_latency", 6, OutRun);
    run_expect("pre_halt_on", 1, OutHalt);
    halt_button = 1'b0;
    run_expect("pre_halt_release", 10, OutHalt);
    reset = 1'b1;
    run_expect("mid_reset", 1, OutHold);
    reset = 1'b0;
    run_expect("mid_hold", 7, OutHold);
    run_expect("mid_run", 1, OutRun);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rvx_run_controller.md
Name: rvx_run_controller

Overview:
Board-level reset and halt sequencer that sits between the raw board buttons and the rvx core's reset/halt inputs. It replaces the single-flop reset sampling used in board tops today. Each button is synchronized and debounced. A power-on or button reset is stretched to a guaranteed minimum length, and a halt button toggles the core between running and halted. All outputs are registered so they drive rvx directly.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per button input (must be at least 2)
DEBOUNCE_CYCLES, 120000, consecutive stable cycles needed to accept a button level change (10 ms at 12 MHz; must be at least 1)
RESET_HOLD_CYCLES, 16, cycles core_reset stays high after each reset source clears (must be at least 1)

Ports:
clock  input  1  system clock, single clock domain
reset  input  1  block reset, synchronous, active-high (power-on / clock-lock derived)
reset_button  input  1  raw reset pushbutton, asynchronous, active-high
halt_button  input  1  raw halt pushbutton, asynchronous, active-high
core_reset  output  1  drives rvx reset, active-high
core_halt  output  1  drives rvx halt, active-high
running  output  1  status: core out of reset and not halted

Behaviour:
- Reset values (reset=1, takes effect on the clock edge):
  - All synchronizer flops = 0; debounced levels = 0; debounce counters = 0.
  - Halt edge-detect register = 0; hold counter = 0; state = HOLD.
  - Outputs: core_reset = 1, core_halt = 0, running = 0.
- Synchronizer: SYNC_STAGES-flop chain per button.
- Debounce, per button:
  - Counter increments while the synchronized input differs from the debounced level; it clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, the debounced level flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Latency: from a stable raw button change to a registered output change is SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Halt press is the rising edge of the debounced halt level. Halt releases are ignored.
- FSM states HOLD, WAIT_RELEASE, RUN, HALTED. Outputs are registered from the next state.
  - HOLD:
    - Outputs: core_reset = 1, core_halt = 0, running = 0.
    - Hold counter increments each cycle.
    - At count RESET_HOLD_CYCLES-1: go to WAIT_RELEASE if debounced reset is high, else RUN.
    - core_reset is therefore high for exactly RESET_HOLD_CYCLES cycles after reset deasserts.
  - WAIT_RELEASE:
    - Outputs: core_reset = 1, core_halt = 0.
    - When debounced reset goes low: go to HOLD with the hold counter cleared.
  - RUN:
    - Outputs: core_reset = 0, core_halt = 0, running = 1.
    - Debounced reset high -> WAIT_RELEASE.
    - Else halt press -> HALTED.
  - HALTED:
    - Outputs: core_reset = 0, core_halt = 1, running = 0.
    - Debounced reset high -> WAIT_RELEASE; this clears halt.
    - Else halt press -> RUN.
- Priority:
  - reset port beats everything.
  - Debounced reset button beats a halt press arriving in the same cycle.
  - Halt presses during HOLD or WAIT_RELEASE are discarded; the edge register still tracks the level, so no press is deferred.
- Reset asserted mid-operation, from any state: next cycle core_reset = 1, core_halt = 0, state = HOLD. Debounce state is lost, and a button still held is re-debounced from 0.
- core_reset and core_halt are never both 1.

Decomposition:
- Shared package rvx_board_pkg holds the FSM state encoding localparams (HOLD=2'd0, WAIT_RELEASE=2'd1, RUN=2'd2, HALTED=2'd3) and the default debounce constant, for reuse by other board tops.
- One natural sub-module, rvx_button_debouncer, containing the synchronizer plus debounce counter (params SYNC_STAGES, DEBOUNCE_CYCLES; ports clock, reset, button_in, level_out). It is instantiated twice.
- The FSM, hold counter and halt edge detect stay in rvx_run_controller.

Test Plan:
(Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8.)
1. Power-on: reset high 3 cycles, then low with buttons idle -> core_reset=1 for exactly 8 cycles after release, then core_reset=0 and running=1.
2. Glitch rejection: in RUN, halt_button high 3 cycles then low -> core_halt stays 0. Halt_button high 10 cycles -> core_halt=1 exactly 7 cycles after the rising edge, running=0.
3. Halt toggle: from HALTED, release halt_button, then press for 10 cycles -> core_halt returns to 0 at rising edge +7 cycles, running=1.
4. Button reset: in RUN, reset_button high 20 cycles -> core_reset=1 at +7 cycles and stays high while held. After release, core_reset remains high 7 (debounce) + 8 (hold) cycles, then RUN.
5. Simultaneous: in RUN, both buttons rise on the same cycle -> WAIT_RELEASE, core_halt never asserts. After release the core returns to RUN, not HALTED.
6. Mid-operation reset: in HALTED, pulse reset for 1 cycle -> next cycle core_reset=1 and core_halt=0, then 8-cycle hold, then RUN.
